mips_processor: RTL and testbench
=================================

# mips_processor

Single-cycle 32-bit MIPS core: fetches, decodes, executes and retires one instruction per rising clock edge. Top of the CPU hierarchy; contains the instruction fetch unit (with a byte-addressed instruction memory), a 32×32 register file, ALU, control decoder and a byte-addressed data memory. Benches preload programs through hierarchical memory access; there is no external bus.

## Interface
- No parameters. Memory sizes are fixed: IMEM 1024 bytes, DMEM 1024 bytes.
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- pc  output  32  address of the instruction currently executing.
- Fixed hierarchy for bench access:
  - IFU.imemory.storage.bytes[0:1023], 8-bit entries, loadable with $readmemb, one byte per line.
  - registers.registers[0:31], 32-bit entries.
  - DMEM: dmemory.storage.bytes[0:1023], 8-bit entries.

## Operation
- Instruction fetch: big-endian word from IMEM bytes pc..pc+3 (byte pc is bits 31:24). pc[1:0] always 0.
- Supported instructions:
  - R-type (op 0): add, addu, sub, subu, and, or, xor, nor, slt, sltu, sll, srl, sra, jr.
  - I-type: addi, addiu, andi, ori, xori, slti, sltiu, lui, lw, sw, beq, bne.
  - J-type: j, jal (jal writes pc+4 to $31).
- addi/addiu/slti/lw/sw/beq/bne: 16-bit immediate sign-extended. andi/ori/xori: zero-extended. lui: imm<<16.
- Arithmetic wraps modulo 2^32; no overflow exception (add and addu behave identically).
- slt/slti signed compare; sltu/sltiu unsigned; result 0 or 1.
- Register $0 always reads 0; writes to it are discarded.
- Register file: two asynchronous read ports, one write port, written on rising edge.
- lw/sw: effective address rs+sext(imm), big-endian word, address bits [1:0] ignored, wraps within 1024 bytes (addr[9:0]). DMEM read combinational, write on rising edge.
- Next PC: branch taken → pc+4+(sext(imm)<<2); j/jal → {pc+4[31:28], target, 2'b00}; jr → rs; else pc+4. IMEM index uses pc[9:0].
- Undefined opcode/funct: no state change except pc+4 (NOP).

## Timing
- rst_n low (asynchronous): pc=0, all 32 registers=0 immediately; DMEM and IMEM contents retained.
- Reset assertion mid-program aborts the in-flight instruction; no write from it occurs.
- After rst_n rises, the first rising clk edge retires the instruction at address 0; the Nth edge retires the Nth instruction of straight-line code.
- Latency: one cycle per instruction; register/DMEM results visible immediately after the retiring edge.
- Same-cycle read-after-write: an instruction reads the value written by the previous instruction (written at the previous edge).
- pc output changes only at rising edges or on reset.

## Configuration
- MIPS_TRACE_EN: when defined, each retiring edge $display's time, pc, instruction word, and any register/DMEM write (index/address and value). When undefined, no display statements exist; functional behaviour identical.

## Test plan
- addi: program addi $16,$0,0; addi $17,$0,3; addi $8,$0,255; addi $9,$0,-3 → after 4 edges: $16=0, $17=3, $8=255, $9=0xFFFFFFFD.
- R-type: $8=7, $9=5 via addi; add $10,$8,$9; sub $11,$9,$8; slt $12,$11,$0; sltu $13,$11,$0 → $10=12, $11=0xFFFFFFFE, $12=1, $13=0.
- Memory: addi $8,$0,0x1234; sw $8,8($0); lw $9,8($0) → $9=0x1234; DMEM bytes[8..11]=00,00,12,34.
- Control flow: beq taken skips next instruction; bne not taken falls through; j to address 0x20; jal sets $31=pc+4 → skipped instruction leaves its target register 0, pc sequence matches.
- $zero and wrap: addi $0,$0,5 → $0 reads 0; addi of 0x7FFFFFFF+1 → 0x80000000, no trap.
- Reset: pulse rst_n low between clock edges after 2 instructions → pc=0 and all registers 0 before next edge; program re-executes from address 0.

Source files
------------

// File: rtl/mips_processor.sv
// mips_processor: single-cycle 32-bit MIPS core with byte-addressed IMEM/DMEM.
// Define MIPS_TRACE_EN to print a per-instruction retire trace.
module mips_storage (
  input  logic        clk,
  input  logic        we,
  input  logic [9:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);
  logic [7:0] bytes [0:1023];
  logic       unused_lsb;
  assign unused_lsb = ^addr[1:0];
  assign rdata = {bytes[{addr[9:2], 2'd0}], bytes[{addr[9:2], 2'd1}],
                  bytes[{addr[9:2], 2'd2}], bytes[{addr[9:2], 2'd3}]};
  always_ff @(posedge clk)
    if (we) begin
      bytes[{addr[9:2], 2'd0}] <= wdata[31:24];
      bytes[{addr[9:2], 2'd1}] <= wdata[23:16];
      bytes[{addr[9:2], 2'd2}] <= wdata[15:8];
      bytes[{addr[9:2], 2'd3}] <= wdata[7:0];
    end
endmodule

module mips_imem (
  input  logic        clk,
  input  logic [9:0]  addr,
  output logic [31:0] instr
);
  mips_storage storage (.clk(clk), .we(1'b0), .addr(addr), .wdata(32'd0), .rdata(instr));
endmodule

module mips_dmem (
  input  logic        clk,
  input  logic        we,
  input  logic [9:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);
  mips_storage storage (.clk(clk), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata));
endmodule

module mips_ifu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] next_pc,
  output logic [31:0] pc,
  output logic [31:0] instr
);
  logic [31:0] pc_d, pc_q;
  always_comb pc_d = next_pc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pc_q <= '0;
    else pc_q <= pc_d;
  assign pc = pc_q;
  mips_imem imemory (.clk(clk), .addr(pc_q[9:0]), .instr(instr));
endmodule

module mips_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] registers [0:31];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < 32; i++) registers[i] <= '0;
    else if (we && wa != 5'd0) registers[wa] <= wd;
  assign rd1 = (ra1 == 5'd0) ? '0 : registers[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : registers[ra2];
endmodule

module mips_processor (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc
);
  logic [31:0] instr, rs_v, rt_v, sext, zext, pc4, ea, dm_rdata, wr_val, next_pc;
  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd, sh, wr_idx;
  logic [15:0] imm;
  logic        wr_en, mem_we, unused_ea;
  assign op   = instr[31:26];
  assign rs   = instr[25:21];
  assign rt   = instr[20:16];
  assign rd   = instr[15:11];
  assign sh   = instr[10:6];
  assign fn   = instr[5:0];
  assign imm  = instr[15:0];
  assign sext = {{16{imm[15]}}, imm};
  assign zext = {16'd0, imm};
  assign pc4  = pc + 32'd4;
  assign ea   = rs_v + sext;
  assign unused_ea = ^ea[31:10];
  mips_ifu IFU (.clk(clk), .rst_n(rst_n), .next_pc(next_pc), .pc(pc), .instr(instr));
  mips_regfile registers (
    .clk(clk), .rst_n(rst_n), .we(wr_en), .wa(wr_idx), .wd(wr_val),
    .ra1(rs), .ra2(rt), .rd1(rs_v), .rd2(rt_v)
  );
  // Gating with rst_n keeps clock edges during a held reset from touching DMEM.
  mips_dmem dmemory (
    .clk(clk), .we(mem_we & rst_n), .addr(ea[9:0]), .wdata(rt_v), .rdata(dm_rdata)
  );
  always_comb begin
    wr_en   = 1'b1;
    wr_idx  = rt;
    wr_val  = '0;
    mem_we  = 1'b0;
    next_pc = pc4;
    case (op)
      6'h00: begin
        wr_idx = rd;
        case (fn)
          6'h00: wr_val = rt_v << sh;
          6'h02: wr_val = rt_v >> sh;
          6'h03: wr_val = $signed(rt_v) >>> sh;
          6'h08: begin
            wr_en   = 1'b0;
            next_pc = rs_v;
          end
          6'h20, 6'h21: wr_val = rs_v + rt_v;
          6'h22, 6'h23: wr_val = rs_v - rt_v;
          6'h24: wr_val = rs_v & rt_v;
          6'h25: wr_val = rs_v | rt_v;
          6'h26: wr_val = rs_v ^ rt_v;
          6'h27: wr_val = ~(rs_v | rt_v);
          6'h2a: wr_val = {31'd0, $signed(rs_v) < $signed(rt_v)};
          6'h2b: wr_val = {31'd0, rs_v < rt_v};
          default: wr_en = 1'b0;
        endcase
      end
      6'h02: begin
        wr_en   = 1'b0;
        next_pc = {pc4[31:28], instr[25:0], 2'b00};
      end
      6'h03: begin
        wr_idx  = 5'd31;
        wr_val  = pc4;
        next_pc = {pc4[31:28], instr[25:0], 2'b00};
      end
      6'h04: begin
        wr_en   = 1'b0;
        next_pc = (rs_v == rt_v) ? pc4 + {sext[29:0], 2'b00} : pc4;
      end
      6'h05: begin
        wr_en   = 1'b0;
        next_pc = (rs_v != rt_v) ? pc4 + {sext[29:0], 2'b00} : pc4;
      end
      6'h08, 6'h09: wr_val = rs_v + sext;
      6'h0a: wr_val = {31'd0, $signed(rs_v) < $signed(sext)};
      6'h0b: wr_val = {31'd0, rs_v < sext};
      6'h0c: wr_val = rs_v & zext;
      6'h0d: wr_val = rs_v | zext;
      6'h0e: wr_val = rs_v ^ zext;
      6'h0f: wr_val = {imm, 16'd0};
      6'h23: wr_val = dm_rdata;
      6'h2b: begin
        wr_en  = 1'b0;
        mem_we = 1'b1;
      end
      default: wr_en = 1'b0;
    endcase
  end
`ifdef MIPS_TRACE_EN
  always_ff @(posedge clk)
    if (rst_n) begin
      $display("%0t pc=%08h ins=%08h", $time, pc, instr);
      if (wr_en && wr_idx != 5'd0) $display("%0t   r%0d <= %08h", $time, wr_idx, wr_val);
      if (mem_we) $display("%0t   mem[%03h] <= %08h", $time, {ea[9:2], 2'b00}, rt_v);
    end
`endif
endmodule

// File: tb/tb_mips_processor.sv
// tb_mips_processor: directed ISA programs plus random straight-line programs checked against an ISA-level model.
module tb_mips_processor;
  localparam int ADD = 0, ADDU = 1, SUB = 2, SUBU = 3, AND_ = 4, OR_ = 5, XOR_ = 6, NOR_ = 7,
                 SLT = 8, SLTU = 9, SLL = 10, SRL = 11, SRA = 12, ADDI = 13, ADDIU = 14,
                 SLTI = 15, SLTIU = 16, ANDI = 17, ORI = 18, XORI = 19, LUI = 20, LW = 21,
                 SW = 22, BEQ = 23, BNE = 24, NKIND = 25;
  typedef struct {
    int k;
    int rs;
    int rt;
    int rd;
    int sh;
    logic [15:0] imm;
  } ins_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] pc;
  int checks = 0;
  int errors = 0;
  logic [31:0] prog [$];
  logic [31:0] m_rf [0:31];
  logic [7:0]  m_mem [0:1023];
  logic [31:0] m_pc;
  mips_processor dut (.clk(clk), .rst_n(rst_n), .pc(pc));
  always #5 clk = ~clk;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] r_ins(int fn, int rs, int rt, int rd, int sh);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction
  function automatic logic [31:0] i_ins(int op, int rs, int rt, int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  function automatic logic [31:0] j_ins(int op, int addr);
    return {6'(op), 26'(addr >> 2)};
  endfunction
  function automatic logic [31:0] reg_of(int i);
    return dut.registers.registers[i];
  endfunction
  function automatic logic [31:0] dmem_word(int a);
    return {dut.dmemory.storage.bytes[a], dut.dmemory.storage.bytes[a+1],
            dut.dmemory.storage.bytes[a+2], dut.dmemory.storage.bytes[a+3]};
  endfunction
  task automatic load();
    logic [31:0] w;
    for (int i = 0; i < 256; i++) begin
      w = (i < prog.size()) ? prog[i] : 32'd0;
      dut.IFU.imemory.storage.bytes[4*i]   = w[31:24];
      dut.IFU.imemory.storage.bytes[4*i+1] = w[23:16];
      dut.IFU.imemory.storage.bytes[4*i+2] = w[15:8];
      dut.IFU.imemory.storage.bytes[4*i+3] = w[7:0];
    end
    for (int i = 0; i < 1024; i++) begin
      dut.dmemory.storage.bytes[i] = 8'd0;
      m_mem[i] = 8'd0;
    end
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    m_pc = 32'd0;
  endtask
  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  function automatic logic [31:0] encode(ins_t x);
    case (x.k)
      ADD:   return r_ins('h20, x.rs, x.rt, x.rd, 0);
      ADDU:  return r_ins('h21, x.rs, x.rt, x.rd, 0);
      SUB:   return r_ins('h22, x.rs, x.rt, x.rd, 0);
      SUBU:  return r_ins('h23, x.rs, x.rt, x.rd, 0);
      AND_:  return r_ins('h24, x.rs, x.rt, x.rd, 0);
      OR_:   return r_ins('h25, x.rs, x.rt, x.rd, 0);
      XOR_:  return r_ins('h26, x.rs, x.rt, x.rd, 0);
      NOR_:  return r_ins('h27, x.rs, x.rt, x.rd, 0);
      SLT:   return r_ins('h2a, x.rs, x.rt, x.rd, 0);
      SLTU:  return r_ins('h2b, x.rs, x.rt, x.rd, 0);
      SLL:   return r_ins('h00, 0, x.rt, x.rd, x.sh);
      SRL:   return r_ins('h02, 0, x.rt, x.rd, x.sh);
      SRA:   return r_ins('h03, 0, x.rt, x.rd, x.sh);
      ADDI:  return i_ins('h08, x.rs, x.rt, int'(x.imm));
      ADDIU: return i_ins('h09, x.rs, x.rt, int'(x.imm));
      SLTI:  return i_ins('h0a, x.rs, x.rt, int'(x.imm));
      SLTIU: return i_ins('h0b, x.rs, x.rt, int'(x.imm));
      ANDI:  return i_ins('h0c, x.rs, x.rt, int'(x.imm));
      ORI:   return i_ins('h0d, x.rs, x.rt, int'(x.imm));
      XORI:  return i_ins('h0e, x.rs, x.rt, int'(x.imm));
      LUI:   return i_ins('h0f, 0, x.rt, int'(x.imm));
      LW:    return i_ins('h23, x.rs, x.rt, int'(x.imm));
      SW:    return i_ins('h2b, x.rs, x.rt, int'(x.imm));
      BEQ:   return i_ins('h04, x.rs, x.rt, int'(x.imm));
      default: return i_ins('h05, x.rs, x.rt, int'(x.imm));
    endcase
  endfunction
  task automatic model_exec(ins_t x);
    logic [31:0] a, b, se, ze, v, nxt;
    int d, ea;
    a   = m_rf[x.rs];
    b   = m_rf[x.rt];
    se  = {{16{x.imm[15]}}, x.imm};
    ze  = {16'd0, x.imm};
    nxt = m_pc + 4;
    d   = 0;
    v   = 32'd0;
    ea  = int'((a + se) % 1024) & ~3;
    case (x.k)
      ADD, ADDU:   begin d = x.rd; v = a + b; end
      SUB, SUBU:   begin d = x.rd; v = a - b; end
      AND_:        begin d = x.rd; v = a & b; end
      OR_:         begin d = x.rd; v = a | b; end
      XOR_:        begin d = x.rd; v = a ^ b; end
      NOR_:        begin d = x.rd; v = ~(a | b); end
      SLT:         begin d = x.rd; v = ($signed(a) < $signed(b)) ? 1 : 0; end
      SLTU:        begin d = x.rd; v = (a < b) ? 1 : 0; end
      SLL:         begin d = x.rd; v = b << x.sh; end
      SRL:         begin d = x.rd; v = b >> x.sh; end
      SRA:         begin d = x.rd; v = 32'($signed(b) >>> x.sh); end
      ADDI, ADDIU: begin d = x.rt; v = a + se; end
      SLTI:        begin d = x.rt; v = ($signed(a) < $signed(se)) ? 1 : 0; end
      SLTIU:       begin d = x.rt; v = (a < se) ? 1 : 0; end
      ANDI:        begin d = x.rt; v = a & ze; end
      ORI:         begin d = x.rt; v = a | ze; end
      XORI:        begin d = x.rt; v = a ^ ze; end
      LUI:         begin d = x.rt; v = {x.imm, 16'd0}; end
      LW:          begin d = x.rt; v = {m_mem[ea], m_mem[ea+1], m_mem[ea+2], m_mem[ea+3]}; end
      SW:          {m_mem[ea], m_mem[ea+1], m_mem[ea+2], m_mem[ea+3]} = b;
      BEQ:         if (a == b) nxt = m_pc + 4 + (se << 2);
      default:     if (a != b) nxt = m_pc + 4 + (se << 2);
    endcase
    if (d != 0) m_rf[d] = v;
    m_pc = nxt;
  endtask
  initial begin
    ins_t q [$];
    ins_t x;
    int steps;
    // addi immediates, including a negative one
    prog = '{i_ins(8, 0, 16, 0), i_ins(8, 0, 17, 3), i_ins(8, 0, 8, 255), i_ins(8, 0, 9, -3)};
    load();
    pulse_reset();
    check("rst_pc", pc, 32'd0);
    check("rst_r17", reg_of(17), 32'd0);
    repeat (4) step();
    check("addi_r16", reg_of(16), 32'd0);
    check("addi_r17", reg_of(17), 32'd3);
    check("addi_r8", reg_of(8), 32'd255);
    check("addi_r9", reg_of(9), 32'hFFFFFFFD);
    check("addi_pc", pc, 32'd16);
    // R-type arithmetic and compares
    prog = '{i_ins(8, 0, 8, 7), i_ins(8, 0, 9, 5), r_ins('h20, 8, 9, 10, 0),
             r_ins('h22, 9, 8, 11, 0), r_ins('h2a, 11, 0, 12, 0), r_ins('h2b, 11, 0, 13, 0)};
    load();
    pulse_reset();
    repeat (6) step();
    check("r_add", reg_of(10), 32'd12);
    check("r_sub", reg_of(11), 32'hFFFFFFFE);
    check("r_slt", reg_of(12), 32'd1);
    check("r_sltu", reg_of(13), 32'd0);
    // store then load
    prog = '{i_ins(8, 0, 8, 'h1234), i_ins('h2b, 0, 8, 8), i_ins('h23, 0, 9, 8)};
    load();
    pulse_reset();
    repeat (3) step();
    check("mem_lw", reg_of(9), 32'h1234);
    check("mem_bytes", dmem_word(8), 32'h00001234);
    // control flow: beq taken, bne not taken, j, jal, jr
    prog = '{i_ins(8, 0, 8, 1), i_ins(4, 8, 8, 1), i_ins(8, 0, 9, 7), i_ins(5, 8, 8, 1),
             i_ins(8, 0, 10, 5), j_ins(2, 'h20), i_ins(8, 0, 11, 9), i_ins(8, 0, 11, 9),
             j_ins(3, 'h30), i_ins(8, 0, 12, 1), i_ins(8, 0, 14, 1), i_ins(8, 0, 14, 1),
             i_ins(8, 0, 13, 3), r_ins('h08, 31, 0, 0, 0)};
    load();
    pulse_reset();
    foreach (prog[i]) if (i < 9) begin
      int exp_pc [9] = '{4, 12, 16, 20, 32, 48, 52, 36, 40};
      step();
      check($sformatf("cf_pc%0d", i), pc, 32'(exp_pc[i]));
    end
    check("cf_beq_skip", reg_of(9), 32'd0);
    check("cf_bne_fall", reg_of(10), 32'd5);
    check("cf_j_skip", reg_of(11), 32'd0);
    check("cf_jal_link", reg_of(31), 32'd36);
    check("cf_jal_skip", reg_of(14), 32'd0);
    check("cf_jr", reg_of(12), 32'd1);
    // $zero and signed wrap
    prog = '{i_ins(8, 0, 0, 5), i_ins('h0f, 0, 8, 'h7FFF), i_ins('h0d, 8, 8, 'hFFFF), i_ins(8, 8, 9, 1)};
    load();
    pulse_reset();
    repeat (4) step();
    check("zero_reg", reg_of(0), 32'd0);
    check("wrap_max", reg_of(8), 32'h7FFFFFFF);
    check("wrap_add", reg_of(9), 32'h80000000);
    // asynchronous reset mid-program
    prog = '{i_ins(8, 0, 8, 1), i_ins(8, 0, 9, 2), i_ins(8, 0, 10, 3)};
    load();
    pulse_reset();
    repeat (2) step();
    check("mid_pre_r9", reg_of(9), 32'd2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_pc", pc, 32'd0);
    check("mid_rst_r8", reg_of(8), 32'd0);
    check("mid_rst_r9", reg_of(9), 32'd0);
    #1;
    rst_n = 1'b1;
    step();
    check("mid_rerun_r8", reg_of(8), 32'd1);
    check("mid_rerun_r9", reg_of(9), 32'd0);
    check("mid_rerun_pc", pc, 32'd4);
    // random straight-line programs against the ISA model
    for (int p = 0; p < 4; p++) begin
      q.delete();
      prog.delete();
      for (int i = 0; i < 40; i++) begin
        x.k   = int'($urandom_range(0, NKIND - 1));
        x.rs  = int'($urandom_range(0, 7));
        x.rt  = int'($urandom_range(0, 7));
        x.rd  = int'($urandom_range(0, 7));
        x.sh  = int'($urandom_range(0, 31));
        x.imm = 16'($urandom);
        if (x.k == BEQ || x.k == BNE) x.imm = 16'($urandom_range(0, 2));
        q.push_back(x);
        prog.push_back(encode(x));
      end
      load();
      pulse_reset();
      steps = 0;
      while (m_pc < 160 && steps < 200) begin
        model_exec(q[m_pc >> 2]);
        step();
        steps++;
        check($sformatf("rnd%0d_pc", p), pc, m_pc);
        for (int r = 0; r < 8; r++) check($sformatf("rnd%0d_r%0d", p, r), reg_of(r), m_rf[r]);
      end
      for (int a = 0; a < 1024; a += 4)
        check($sformatf("rnd%0d_mem%03h", p, a), dmem_word(a),
              {m_mem[a], m_mem[a+1], m_mem[a+2], m_mem[a+3]});
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
